sp_mem_arbiter: RTL and testbench

- Shares one single-port SRAM between two requesters on the tile memory side.
- Port 0 is the core data port. Port 1 is the AXI-to-memory bridge, and it takes the bridge's mem_req/addr/we/be/wdata outputs directly.
- Grants one access per cycle and routes the one-cycle-latency read data back to the granted port.
- Arbitration is either round-robin or fixed-priority with a starvation guard.

---
 rtl/sp_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_sp_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_mem_arbiter.sv
// Two-port arbiter in front of one single-port SRAM.
// One grant per cycle; the registered response is steered back to the port that won.
module sp_mem_arbiter #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 64,
   parameter int FIX_PRIO     = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,

   input  logic                    p0_req_i,
   output logic                    p0_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   input  logic                    p0_we_i,
   input  logic [DATA_WIDTH/8-1:0] p0_be_i,
   input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,

   input  logic                    p1_req_i,
   output logic                    p1_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic                    p1_we_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,

   output logic                    mem_req_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   logic [1:0]            req;
   logic [1:0]            gnt;
   logic                  force_p1;
   logic                  last_gnt_reg;
   logic [7:0]            starve_cnt_reg;
   logic [7:0]            starve_cnt_next;
   logic                  resp_valid_reg;
   logic                  resp_sel_reg;
   logic                  resp_we_reg;
   logic [1:0]            rvalid;
   logic [DATA_WIDTH-1:0] rdata [2];

   assign req = {p1_req_i, p0_req_i};

   // Tie-break: round-robin favours the port that did not win last; fixed
   // priority favours port 0 until port 1 has been denied STARVE_LIMIT times.
   always_comb begin
      gnt      = 2'b00;
      force_p1 = 1'b0;
      if (FIX_PRIO != 0) begin
         force_p1 = (starve_cnt_reg == LIMIT);
      end
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11: begin
            if (FIX_PRIO != 0) gnt = force_p1 ? 2'b10 : 2'b01;
            else               gnt = last_gnt_reg ? 2'b01 : 2'b10;
         end
         default: gnt = 2'b00;
      endcase
   end

   assign p0_gnt_o = gnt[0];
   assign p1_gnt_o = gnt[1];

   always_comb begin
      starve_cnt_next = 8'd0;
      if ((FIX_PRIO != 0) && req[1] && !gnt[1]) begin
         starve_cnt_next = (starve_cnt_reg >= LIMIT) ? LIMIT : starve_cnt_reg + 8'd1;
      end
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (gnt[0]) begin
         mem_req_o   = 1'b1;
         mem_addr_o  = p0_addr_i;
         mem_we_o    = p0_we_i;
         mem_be_o    = p0_be_i;
         mem_wdata_o = p0_wdata_i;
      end else if (gnt[1]) begin
         mem_req_o   = 1'b1;
         mem_addr_o  = p1_addr_i;
         mem_we_o    = p1_we_i;
         mem_be_o    = p1_be_i;
         mem_wdata_o = p1_wdata_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt_reg   <= 1'b1;
         starve_cnt_reg <= 8'd0;
         resp_valid_reg <= 1'b0;
         resp_sel_reg   <= 1'b0;
         resp_we_reg    <= 1'b0;
      end else begin
         if (|gnt) last_gnt_reg <= gnt[1];
         starve_cnt_reg <= starve_cnt_next;
         resp_valid_reg <= |gnt;
         resp_sel_reg   <= gnt[1];
         resp_we_reg    <= mem_we_o;
      end
   end

   // Write acknowledgements pulse rvalid but carry zero data.
   for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      assign rvalid[gi] = resp_valid_reg & (resp_sel_reg == 1'(gi));
      assign rdata[gi]  = (rvalid[gi] && !resp_we_reg) ? mem_rdata_i : '0;
   end

   assign p0_rvalid_o = rvalid[0];
   assign p1_rvalid_o = rvalid[1];
   assign p0_rdata_o  = rdata[0];
   assign p1_rdata_o  = rdata[1];

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Bench for sp_mem_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a spec-level model is compared on every falling edge, plus directed literal checks.
module tb_sp_mem_arbiter;

   localparam int AW  = 10;
   localparam int DW  = 64;
   localparam int BW  = DW / 8;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [BW-1:0] p0_be = '0, p1_be = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0, mem_rdata = '0;

   logic          p0_gnt [2], p1_gnt [2], p0_rvalid [2], p1_rvalid [2];
   logic          mem_req [2], mem_we [2];
   logic [AW-1:0] mem_addr [2];
   logic [BW-1:0] mem_be [2];
   logic [DW-1:0] mem_wdata [2], p0_rdata [2], p1_rdata [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Instance 0 is round-robin, instance 1 fixed priority.
   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      sp_mem_arbiter #(
         .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIX_PRIO(gi), .STARVE_LIMIT(LIM)
      ) dut (
         .clk(clk), .rst(rst),
         .p0_req_i(p0_req), .p0_gnt_o(p0_gnt[gi]), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
         .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid[gi]), .p0_rdata_o(p0_rdata[gi]),
         .p1_req_i(p1_req), .p1_gnt_o(p1_gnt[gi]), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
         .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid[gi]), .p1_rdata_o(p1_rdata[gi]),
         .mem_req_o(mem_req[gi]), .mem_addr_o(mem_addr[gi]), .mem_we_o(mem_we[gi]),
         .mem_be_o(mem_be[gi]), .mem_wdata_o(mem_wdata[gi]), .mem_rdata_i(mem_rdata)
      );
   end

   task automatic check(input string name, input int k, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, got, want);
      end
   endtask

   // Model state: who won last, how long port 1 has waited, pending response.
   int m_last [2]   = '{1, 1};
   int m_denied [2] = '{0, 0};
   bit m_pv [2]     = '{0, 0};
   int m_pport [2]  = '{0, 0};
   bit m_pwe [2]    = '{0, 0};
   int e_win [2]    = '{-1, -1};

   always @(negedge clk) begin : cmp
      int            win;
      bit            rv0, rv1;
      logic [AW-1:0] ea;
      logic          ew;
      logic [BW-1:0] eb;
      logic [DW-1:0] ed;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_last[k] = 1; m_denied[k] = 0; m_pv[k] = 0;
         end
         if (p0_req && p1_req) begin
            if (k == 0) win = 1 - m_last[k];
            else        win = (m_denied[k] == LIM) ? 1 : 0;
         end else if (p0_req) win = 0;
         else if (p1_req)     win = 1;
         else                 win = -1;
         e_win[k] = win;

         ea = '0; ew = 1'b0; eb = '0; ed = '0;
         if (win == 0) begin
            ea = p0_addr; ew = p0_we; eb = p0_be; ed = p0_wdata;
         end else if (win == 1) begin
            ea = p1_addr; ew = p1_we; eb = p1_be; ed = p1_wdata;
         end
         check("p0_gnt", k, 64'(p0_gnt[k]), 64'(win == 0));
         check("p1_gnt", k, 64'(p1_gnt[k]), 64'(win == 1));
         check("mem_req", k, 64'(mem_req[k]), 64'(win >= 0));
         check("mem_addr", k, 64'(mem_addr[k]), 64'(ea));
         check("mem_we", k, 64'(mem_we[k]), 64'(ew));
         check("mem_be", k, 64'(mem_be[k]), 64'(eb));
         check("mem_wdata", k, mem_wdata[k], ed);

         rv0 = m_pv[k] && (m_pport[k] == 0);
         rv1 = m_pv[k] && (m_pport[k] == 1);
         check("p0_rvalid", k, 64'(p0_rvalid[k]), 64'(rv0));
         check("p1_rvalid", k, 64'(p1_rvalid[k]), 64'(rv1));
         check("p0_rdata", k, p0_rdata[k], (rv0 && !m_pwe[k]) ? mem_rdata : 64'h0);
         check("p1_rdata", k, p1_rdata[k], (rv1 && !m_pwe[k]) ? mem_rdata : 64'h0);

         if (!rst) begin
            m_pv[k]    = (win >= 0);
            m_pport[k] = win;
            m_pwe[k]   = ew;
            if (win >= 0) m_last[k] = win;
            if (k == 1) begin
               if (p1_req && win != 1) m_denied[k] = (m_denied[k] < LIM) ? m_denied[k] + 1 : LIM;
               else                    m_denied[k] = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      mem_rdata = {$urandom, $urandom};
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
      mid();
      step();
      rst = 1'b0;
   endtask

   function automatic int dut_win(input int k);
      return p1_gnt[k] ? 1 : (p0_gnt[k] ? 0 : -1);
   endfunction

   int       rr_exp [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
   int       fp_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
   bit [3:0] pat [8]     = '{4'b0101, 4'b0111, 4'b1101, 4'b0011, 4'b1100, 4'b0000, 4'b1111, 4'b0101};

   initial begin
      #1 rst = 1'b1;
      mid();
      for (int k = 0; k < 2; k++) begin
         check("rst_p0_rvalid", k, 64'(p0_rvalid[k]), 64'h0);
         check("rst_p1_rvalid", k, 64'(p1_rvalid[k]), 64'h0);
      end
      step();
      rst = 1'b0;

      // Port 0 read alone
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h005;
      mid();
      for (int k = 0; k < 2; k++) begin
         check("rd_gnt", k, 64'(p0_gnt[k]), 64'h1);
         check("rd_mem_addr", k, 64'(mem_addr[k]), 64'h005);
      end
      step();
      p0_req = 1'b0; mem_rdata = 64'hDEADBEEF_01234567;
      mid();
      for (int k = 0; k < 2; k++) begin
         check("rd_rvalid", k, 64'(p0_rvalid[k]), 64'h1);
         check("rd_rdata", k, p0_rdata[k], 64'hDEADBEEF_01234567);
         check("rd_p1_rdata", k, p1_rdata[k], 64'h0);
      end
      step();

      // Idle
      for (int i = 0; i < 3; i++) begin
         mid();
         check("idle_mem_req", 0, 64'(mem_req[0]), 64'h0);
         check("idle_mem_addr", 1, 64'(mem_addr[1]), 64'h0);
         step();
      end

      // Both request continuously from reset
      do_reset();
      p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
      p0_addr = 10'h010; p1_addr = 10'h020;
      for (int i = 0; i < 10; i++) begin
         mid();
         check("rr_seq", 0, 64'(dut_win(0)), 64'(rr_exp[i]));
         check("rr_model", 0, 64'(e_win[0]), 64'(rr_exp[i]));
         check("fp_seq", 1, 64'(dut_win(1)), 64'(fp_exp[i]));
         check("fp_model", 1, 64'(e_win[1]), 64'(fp_exp[i]));
         step();
      end

      // Write on port 1, then read on port 0
      p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b1; p1_addr = 10'h3FF;
      p1_be = 8'h0F; p1_wdata = 64'h11223344_55667788;
      mid();
      for (int k = 0; k < 2; k++) begin
         check("wr_mem_we", k, 64'(mem_we[k]), 64'h1);
         check("wr_mem_wdata", k, mem_wdata[k], 64'h11223344_55667788);
      end
      step();
      p1_req = 1'b0; p1_we = 1'b0; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h3FF;
      mem_rdata = 64'hFFFFFFFF_FFFFFFFF;
      mid();
      for (int k = 0; k < 2; k++) begin
         check("wr_rd_mem_we", k, 64'(mem_we[k]), 64'h0);
         check("wr_p1_rvalid", k, 64'(p1_rvalid[k]), 64'h1);
         check("wr_p1_rdata", k, p1_rdata[k], 64'h0);
      end
      step();
      p0_req = 1'b0; mem_rdata = 64'h0BADCAFE_12345678;
      mid();
      for (int k = 0; k < 2; k++) begin
         check("rd_after_wr_rvalid", k, 64'(p0_rvalid[k]), 64'h1);
         check("rd_after_wr_rdata", k, p0_rdata[k], 64'h0BADCAFE_12345678);
      end
      step();

      // Mixed request/write patterns; the model checks every cycle
      for (int i = 0; i < 24; i++) begin
         p0_req = pat[i % 8][0]; p0_we = pat[i % 8][1];
         p1_req = pat[i % 8][2]; p1_we = pat[i % 8][3];
         p0_addr = AW'(i * 7); p1_addr = AW'(1000 - i);
         p0_be = BW'(i); p1_be = BW'(255 - i);
         p0_wdata = {$urandom, $urandom}; p1_wdata = {$urandom, $urandom};
         mid();
         step();
      end

      // Reset during an outstanding read
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 10'h0AA; p1_req = 1'b0; p1_we = 1'b0;
      mid();
      step();
      p0_req = 1'b0; mem_rdata = 64'h55555555_AAAAAAAA;
      #2;
      for (int k = 0; k < 2; k++) check("pre_rst_rvalid", k, 64'(p0_rvalid[k]), 64'h1);
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) check("async_rst_rvalid", k, 64'(p0_rvalid[k]), 64'h0);
      mid();
      step();
      rst = 1'b0; p0_req = 1'b1; p1_req = 1'b1;
      mid();
      for (int k = 0; k < 2; k++) check("post_rst_tie", k, 64'(dut_win(k)), 64'h0);
      step();
      p0_req = 1'b0; p1_req = 1'b0;
      mid();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
